// File: rtl/ysyx_25060173_dmem_responder.sv
// Data-memory responder: one outstanding request, LATENCY wait cycles,
// byte/half/word access to a word-organised RAM with fault detection.
module ysyx_25060173_dmem_responder #(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h80000000,
  parameter int          LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam int          WORDS = 1 << DEPTH_LOG2;
  localparam logic [32:0] LO    = {1'b0, BASE_ADDR};
  localparam logic [32:0] HI    = LO + (33'd4 << DEPTH_LOG2);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wen_q, wen_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [WORDS];

  logic [DEPTH_LOG2-1:0] idx;
  logic [4:0]  sh;
  logic [31:0] word;
  logic        mis;
  logic        oor;
  logic        fault;
  logic [3:0]  be;
  logic [31:0] wmask;
  logic [31:0] wsh;
  logic [31:0] ld;
  logic        exec;

  // Index is only meaningful once the range check has passed
  assign idx   = DEPTH_LOG2'((addr_q - BASE_ADDR) >> 2);
  assign sh    = {addr_q[1:0], 3'b000};
  assign word  = mem[idx];
  assign oor   = ({1'b0, addr_q} < LO) || ({1'b0, addr_q} >= HI);
  assign fault = mis | oor;
  assign exec  = (state_q == S_WAIT) && (cnt_q == 4'd0);
  assign wsh   = wdata_q << sh;

  always_comb begin
    mis = 1'b0;
    be  = 4'b0000;
    ld  = 32'd0;
    unique case (size_q)
      2'd0: begin
        be = 4'b0001 << addr_q[1:0];
        ld = 32'(8'(word >> sh));
      end
      2'd1: begin
        mis = addr_q[0];
        be  = 4'b0011 << addr_q[1:0];
        ld  = 32'(16'(word >> sh));
      end
      2'd2: begin
        mis = |addr_q[1:0];
        be  = 4'b1111;
        ld  = word;
      end
      default: mis = 1'b1;
    endcase
  end

  always_comb begin
    wmask = 32'd0;
    for (int i = 0; i < 4; i++) begin
      wmask[8*i +: 8] = {8{be[i]}};
    end
  end

  always_ff @(posedge clk) begin
    if (exec && wen_q && !fault) begin
      mem[idx] <= (word & ~wmask) | (wsh & wmask);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      wen_q   <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wen_d   = wen_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          wen_d   = req_wen;
          size_d  = req_size;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = 4'(LATENCY);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Counter at zero: this edge is the execute step
        if (cnt_q == 4'd0) begin
          err_d   = fault;
          rdata_d = (fault || wen_q) ? 32'd0 : ld;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          rdata_d = 32'd0;
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == S_IDLE);
    resp_valid = (state_q == S_RESP);
    resp_rdata = rdata_q;
    resp_err   = err_q;
  end

endmodule
